// File: rtl/agc_timing_pkg.sv
// Shared AGC timing constants: scaler depth, channel read-out windows and the scaler count type.
package agc_timing_pkg;
  localparam int SCALER_STAGES = 33;
  localparam int CHAT_BASE     = 5;
  localparam int CHBT_BASE     = 19;
  localparam int CH_WIDTH      = 14;

  typedef logic [SCALER_STAGES-2:0] scaler_cnt_t;
endpackage

// File: rtl/a1_scaler_decode.sv
// Two-phase decode of one scaler stage: A while both stages low, B while this stage high and the previous low.
// Purely combinational, zero latency, no backpressure.
module a1_scaler_decode (
  input  logic fs_prev_i,
  input  logic fs_cur_i,
  output logic fa_o,
  output logic fb_o
);
  assign fa_o = ~fs_prev_i & ~fs_cur_i;
  assign fb_o = ~fs_prev_i &  fs_cur_i;
endmodule

// File: rtl/a1_scaler_block.sv
// AGC timing scaler: 32-stage FS01-driven count, FnnA/FnnB decodes, derived strobes, CHAT/CHBT read-out.
// Stages move 3 SIM_CLK after an FS01_ rise, no backpressure; A1_SCALER_CHANNEL_READ_EN enables bus gating.
module a1_scaler_block
  import agc_timing_pkg::*;
(
  input  logic SIM_CLK,
  input  logic SIM_RST_,
  input  logic FS01_,
  input  logic RCHAT_,
  input  logic RCHBT_,
  output logic FS02, FS03, FS04, FS05, FS06, FS07, FS08, FS09, FS10, FS11, FS12,
  output logic FS13, FS14, FS15, FS16, FS17, FS18, FS19, FS20, FS21, FS22, FS23,
  output logic FS24, FS25, FS26, FS27, FS28, FS29, FS30, FS31, FS32, FS33,
  output logic F02A, F03A, F04A, F05A, F06A, F07A, F08A, F09A, F10A, F11A, F12A,
  output logic F13A, F14A, F15A, F16A, F17A, F18A, F19A, F20A, F21A, F22A, F23A,
  output logic F24A, F25A, F26A, F27A, F28A, F29A, F30A, F31A, F32A, F33A,
  output logic F02B, F03B, F04B, F05B, F06B, F07B, F08B, F09B, F10B, F11B, F12B,
  output logic F13B, F14B, F15B, F16B, F17B, F18B, F19B, F20B, F21B, F22B, F23B,
  output logic F24B, F25B, F26B, F27B, F28B, F29B, F30B, F31B, F32B, F33B,
  output logic FS02A, FS03A, FS04A, FS05A, FS07A,
  output logic FS05_, FS06_, FS07_, FS08_, FS09_,
  output logic F03B_, F04B_, F05A_, F05B_, F06B_, F07A_, F07B_, F08B_,
  output logic F09A_, F09B_, F10A_, F10B_, F17A_, F17B_, F18A_, F18B_,
  output logic F05D, F07C_, F07D_, F09D_, F18AX,
  output logic CHAT01, CHAT02, CHAT03, CHAT04, CHAT05, CHAT06, CHAT07,
  output logic CHAT08, CHAT09, CHAT10, CHAT11, CHAT12, CHAT13, CHAT14,
  output logic CHBT01, CHBT02, CHBT03, CHBT04, CHBT05, CHBT06, CHBT07,
  output logic CHBT08, CHBT09, CHBT10, CHBT11, CHBT12, CHBT13, CHBT14
);
  logic [1:0]             sync_q;
  logic                   hist_q;
  scaler_cnt_t            cnt_q, cnt_d;
  logic                   fs01_fall;
  logic [SCALER_STAGES:1] fs;
  logic [SCALER_STAGES:2] fa, fb;
  logic [CH_WIDTH:1]      chat, chbt;

  // FS01 is the inverse of FS01_, so its falling edge is a rising edge of the synchronized FS01_.
  assign fs01_fall = sync_q[1] & ~hist_q;

  always_comb begin
    cnt_d = cnt_q;
    if (fs01_fall) cnt_d = cnt_q + scaler_cnt_t'(1);
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
    if (!SIM_RST_) begin
      sync_q <= 2'b11;
      hist_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], FS01_};
      hist_q <= sync_q[1];
      cnt_q  <= cnt_d;
    end
  end

  assign fs = {cnt_q, ~sync_q[1]};

  for (genvar n = 2; n <= SCALER_STAGES; n++) begin : g_dec
    a1_scaler_decode u_dec (
      .fs_prev_i (fs[n-1]),
      .fs_cur_i  (fs[n]),
      .fa_o      (fa[n]),
      .fb_o      (fb[n])
    );
  end

`ifdef A1_SCALER_CHANNEL_READ_EN
  assign chat = {CH_WIDTH{~RCHAT_}} & fs[CHAT_BASE+CH_WIDTH-1:CHAT_BASE];
  assign chbt = {CH_WIDTH{~RCHBT_}} & fs[CHBT_BASE+CH_WIDTH-1:CHBT_BASE];
`else
  logic unused_rd;
  assign unused_rd = RCHAT_ ^ RCHBT_;
  assign chat      = '0;
  assign chbt      = '0;
`endif

  assign {FS33, FS32, FS31, FS30, FS29, FS28, FS27, FS26, FS25, FS24, FS23,
          FS22, FS21, FS20, FS19, FS18, FS17, FS16, FS15, FS14, FS13, FS12,
          FS11, FS10, FS09, FS08, FS07, FS06, FS05, FS04, FS03, FS02} = fs[SCALER_STAGES:2];
  assign {F33A, F32A, F31A, F30A, F29A, F28A, F27A, F26A, F25A, F24A, F23A,
          F22A, F21A, F20A, F19A, F18A, F17A, F16A, F15A, F14A, F13A, F12A,
          F11A, F10A, F09A, F08A, F07A, F06A, F05A, F04A, F03A, F02A} = fa;
  assign {F33B, F32B, F31B, F30B, F29B, F28B, F27B, F26B, F25B, F24B, F23B,
          F22B, F21B, F20B, F19B, F18B, F17B, F16B, F15B, F14B, F13B, F12B,
          F11B, F10B, F09B, F08B, F07B, F06B, F05B, F04B, F03B, F02B} = fb;

  assign {FS02A, FS03A, FS04A, FS05A, FS07A} = {fs[2], fs[3], fs[4], fs[5], fs[7]};
  assign {FS05_, FS06_, FS07_, FS08_, FS09_} = ~{fs[5], fs[6], fs[7], fs[8], fs[9]};
  assign {F03B_, F04B_, F05A_, F05B_, F06B_, F07A_, F07B_, F08B_} =
         ~{fb[3], fb[4], fa[5], fb[5], fb[6], fa[7], fb[7], fb[8]};
  assign {F09A_, F09B_, F10A_, F10B_, F17A_, F17B_, F18A_, F18B_} =
         ~{fa[9], fb[9], fa[10], fb[10], fa[17], fb[17], fa[18], fb[18]};

  assign F05D  = fb[5] & ~fs[3];
  assign F07C_ = ~(fa[7] & ~fs[5]);
  assign F07D_ = ~(fb[7] & ~fs[5]);
  assign F09D_ = ~(fb[9] & ~fs[7]);
  assign F18AX = fa[18] & ~fs[16];

  assign {CHAT14, CHAT13, CHAT12, CHAT11, CHAT10, CHAT09, CHAT08,
          CHAT07, CHAT06, CHAT05, CHAT04, CHAT03, CHAT02, CHAT01} = chat;
  assign {CHBT14, CHBT13, CHBT12, CHBT11, CHBT10, CHBT09, CHBT08,
          CHBT07, CHBT06, CHBT05, CHBT04, CHBT03, CHBT02, CHBT01} = chbt;
endmodule

// File: tb/tb_a1_scaler_block.sv
// Self-checking bench for a1_scaler_block against a count-level reference model.
module tb_a1_scaler_block;
  logic SIM_CLK = 1'b0;
  logic SIM_RST_ = 1'b0;
  logic FS01_ = 1'b1;
  logic RCHAT_ = 1'b1;
  logic RCHBT_ = 1'b1;

  wire [33:2]  fs_o, fa_o, fb_o;
  wire [14:1]  chat_o, chbt_o;
  wire [30:0]  misc_o;
  wire [154:0] obs = {fs_o, fa_o, fb_o, chat_o, chbt_o, misc_o};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;
  logic        exp_f1 = 1'b0;
  logic [31:0] force_val = '0;
  logic [154:0] exp_v;
  logic [14:1] want;

`ifdef A1_SCALER_CHANNEL_READ_EN
  localparam bit CH_EN = 1'b1;
`else
  localparam bit CH_EN = 1'b0;
`endif

  always #5 SIM_CLK = ~SIM_CLK;

  a1_scaler_block dut (
    .SIM_CLK(SIM_CLK), .SIM_RST_(SIM_RST_), .FS01_(FS01_), .RCHAT_(RCHAT_), .RCHBT_(RCHBT_),
    .FS02(fs_o[2]), .FS03(fs_o[3]), .FS04(fs_o[4]), .FS05(fs_o[5]), .FS06(fs_o[6]), .FS07(fs_o[7]),
    .FS08(fs_o[8]), .FS09(fs_o[9]), .FS10(fs_o[10]), .FS11(fs_o[11]), .FS12(fs_o[12]), .FS13(fs_o[13]),
    .FS14(fs_o[14]), .FS15(fs_o[15]), .FS16(fs_o[16]), .FS17(fs_o[17]), .FS18(fs_o[18]), .FS19(fs_o[19]),
    .FS20(fs_o[20]), .FS21(fs_o[21]), .FS22(fs_o[22]), .FS23(fs_o[23]), .FS24(fs_o[24]), .FS25(fs_o[25]),
    .FS26(fs_o[26]), .FS27(fs_o[27]), .FS28(fs_o[28]), .FS29(fs_o[29]), .FS30(fs_o[30]), .FS31(fs_o[31]),
    .FS32(fs_o[32]), .FS33(fs_o[33]),
    .F02A(fa_o[2]), .F03A(fa_o[3]), .F04A(fa_o[4]), .F05A(fa_o[5]), .F06A(fa_o[6]), .F07A(fa_o[7]),
    .F08A(fa_o[8]), .F09A(fa_o[9]), .F10A(fa_o[10]), .F11A(fa_o[11]), .F12A(fa_o[12]), .F13A(fa_o[13]),
    .F14A(fa_o[14]), .F15A(fa_o[15]), .F16A(fa_o[16]), .F17A(fa_o[17]), .F18A(fa_o[18]), .F19A(fa_o[19]),
    .F20A(fa_o[20]), .F21A(fa_o[21]), .F22A(fa_o[22]), .F23A(fa_o[23]), .F24A(fa_o[24]), .F25A(fa_o[25]),
    .F26A(fa_o[26]), .F27A(fa_o[27]), .F28A(fa_o[28]), .F29A(fa_o[29]), .F30A(fa_o[30]), .F31A(fa_o[31]),
    .F32A(fa_o[32]), .F33A(fa_o[33]),
    .F02B(fb_o[2]), .F03B(fb_o[3]), .F04B(fb_o[4]), .F05B(fb_o[5]), .F06B(fb_o[6]), .F07B(fb_o[7]),
    .F08B(fb_o[8]), .F09B(fb_o[9]), .F10B(fb_o[10]), .F11B(fb_o[11]), .F12B(fb_o[12]), .F13B(fb_o[13]),
    .F14B(fb_o[14]), .F15B(fb_o[15]), .F16B(fb_o[16]), .F17B(fb_o[17]), .F18B(fb_o[18]), .F19B(fb_o[19]),
    .F20B(fb_o[20]), .F21B(fb_o[21]), .F22B(fb_o[22]), .F23B(fb_o[23]), .F24B(fb_o[24]), .F25B(fb_o[25]),
    .F26B(fb_o[26]), .F27B(fb_o[27]), .F28B(fb_o[28]), .F29B(fb_o[29]), .F30B(fb_o[30]), .F31B(fb_o[31]),
    .F32B(fb_o[32]), .F33B(fb_o[33]),
    .FS02A(misc_o[30]), .FS03A(misc_o[29]), .FS04A(misc_o[28]), .FS05A(misc_o[27]), .FS07A(misc_o[26]),
    .FS05_(misc_o[25]), .FS06_(misc_o[24]), .FS07_(misc_o[23]), .FS08_(misc_o[22]), .FS09_(misc_o[21]),
    .F03B_(misc_o[20]), .F04B_(misc_o[19]), .F05A_(misc_o[18]), .F05B_(misc_o[17]), .F06B_(misc_o[16]),
    .F07A_(misc_o[15]), .F07B_(misc_o[14]), .F08B_(misc_o[13]), .F09A_(misc_o[12]), .F09B_(misc_o[11]),
    .F10A_(misc_o[10]), .F10B_(misc_o[9]), .F17A_(misc_o[8]), .F17B_(misc_o[7]), .F18A_(misc_o[6]),
    .F18B_(misc_o[5]), .F05D(misc_o[4]), .F07C_(misc_o[3]), .F07D_(misc_o[2]), .F09D_(misc_o[1]),
    .F18AX(misc_o[0]),
    .CHAT01(chat_o[1]), .CHAT02(chat_o[2]), .CHAT03(chat_o[3]), .CHAT04(chat_o[4]), .CHAT05(chat_o[5]),
    .CHAT06(chat_o[6]), .CHAT07(chat_o[7]), .CHAT08(chat_o[8]), .CHAT09(chat_o[9]), .CHAT10(chat_o[10]),
    .CHAT11(chat_o[11]), .CHAT12(chat_o[12]), .CHAT13(chat_o[13]), .CHAT14(chat_o[14]),
    .CHBT01(chbt_o[1]), .CHBT02(chbt_o[2]), .CHBT03(chbt_o[3]), .CHBT04(chbt_o[4]), .CHBT05(chbt_o[5]),
    .CHBT06(chbt_o[6]), .CHBT07(chbt_o[7]), .CHBT08(chbt_o[8]), .CHBT09(chbt_o[9]), .CHBT10(chbt_o[10]),
    .CHBT11(chbt_o[11]), .CHBT12(chbt_o[12]), .CHBT13(chbt_o[13]), .CHBT14(chbt_o[14])
  );

  // Expected outputs from the count value, the FS01 level and the read strobes.
  function automatic logic [154:0] model(input logic [31:0] c, input logic f1,
                                         input logic ra_n, input logic rb_n);
    logic [33:1] s;
    logic [33:2] a, b;
    logic [14:1] ca, cb;
    logic [30:0] m;
    s = {c, f1};
    for (int n = 2; n <= 33; n++) begin
      a[n] = !s[n-1] && !s[n];
      b[n] = !s[n-1] && s[n];
    end
    for (int k = 1; k <= 14; k++) begin
      ca[k] = CH_EN && !ra_n && s[k+4];
      cb[k] = CH_EN && !rb_n && s[k+18];
    end
    m = {s[2], s[3], s[4], s[5], s[7], ~s[5], ~s[6], ~s[7], ~s[8], ~s[9],
         ~b[3], ~b[4], ~a[5], ~b[5], ~b[6], ~a[7], ~b[7], ~b[8],
         ~a[9], ~b[9], ~a[10], ~b[10], ~a[17], ~b[17], ~a[18], ~b[18],
         b[5] & ~s[3], ~(a[7] & ~s[5]), ~(b[7] & ~s[5]), ~(b[9] & ~s[7]), a[18] & ~s[16]};
    return {s[33:2], a, b, ca, cb, m};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge SIM_CLK);
  endtask

  task automatic drive_pulse(input int lo, input int hi);
    FS01_ = 1'b0;
    step(lo);
    FS01_ = 1'b1;
    step(hi);
  endtask

  task automatic load_count(input logic [31:0] v);
    force_val = v;
    force dut.cnt_q = force_val;
    step(1);
    release dut.cnt_q;
    #1;
    exp_cnt = v;
  endtask

  task automatic test_reset();
    SIM_RST_ = 1'b0; FS01_ = 1'b1; RCHAT_ = 1'b0; RCHBT_ = 1'b0;
    exp_cnt = '0; exp_f1 = 1'b0;
    step(2);
    for (int i = 0; i < 5; i++) begin
      FS01_ = 1'b0;
      step(3);
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_lo[%0d]: got %h want %h", i, obs, exp_v); end
      FS01_ = 1'b1;
      step(3);
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_hi[%0d]: got %h want %h", i, obs, exp_v); end
    end
    checks++;
    if (fs_o !== '0 || fa_o[2] !== 1'b1 || fb_o[2] !== 1'b0 || chat_o !== '0 || chbt_o !== '0) begin
      errors++;
      $display("FAIL reset_levels: fs %h F02A %b F02B %b chat %h chbt %h want 0/1/0/0/0",
               fs_o, fa_o[2], fb_o[2], chat_o, chbt_o);
    end
    SIM_RST_ = 1'b1; RCHAT_ = 1'b1; RCHBT_ = 1'b1;
    step(4);
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_release: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_single_edge();
    FS01_ = 1'b0;
    step(3);
    exp_f1 = 1'b1;
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL edge_fs01_high: got %h want %h", obs, exp_v); end
    FS01_ = 1'b1;
    step(2);
    exp_f1 = 1'b0;
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL edge_2cyc: got %h want %h", obs, exp_v); end
    step(1);
    exp_cnt = exp_cnt + 1;
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL edge_3cyc: got %h want %h", obs, exp_v); end
    checks++;
    if (fs_o[2] !== 1'b1 || fb_o[2] !== 1'b1) begin
      errors++; $display("FAIL edge_fs02: FS02 %b F02B %b want 1 1", fs_o[2], fb_o[2]);
    end
  endtask

  task automatic test_count();
    while (exp_cnt < 100) begin
      RCHAT_ = 1'($urandom_range(0, 1));
      RCHBT_ = 1'($urandom_range(0, 1));
      FS01_ = 1'b0;
      step($urandom_range(3, 5));
      exp_f1 = 1'b1;
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL count_lo[%0d]: got %h want %h", exp_cnt, obs, exp_v); end
      FS01_ = 1'b1;
      step($urandom_range(3, 5));
      exp_f1 = 1'b0;
      exp_cnt = exp_cnt + 1;
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL count_hi[%0d]: got %h want %h", exp_cnt, obs, exp_v); end
    end
    checks++;
    if (fs_o !== 32'd100) begin errors++; $display("FAIL count_100: fs %h want %h", fs_o, 32'd100); end
  endtask

  task automatic test_channel_read();
    RCHAT_ = 1'b0; RCHBT_ = 1'b1;
    #1;
    want = CH_EN ? 14'b00_0000_0000_1100 : 14'b0;
    checks++;
    if (chat_o !== want || chbt_o !== '0) begin
      errors++; $display("FAIL chat_100: chat %h chbt %h want %h 0", chat_o, chbt_o, want);
    end
    RCHBT_ = 1'b0;
    #1;
    checks++;
    if (chbt_o !== '0 || chat_o !== want) begin
      errors++; $display("FAIL chbt_100: chbt %h chat %h want 0 %h", chbt_o, chat_o, want);
    end
    RCHAT_ = 1'b1;
    #1;
    checks++;
    if (chat_o !== '0) begin errors++; $display("FAIL chat_release: chat %h want 0", chat_o); end
    for (int i = 0; i < 4; i++) begin
      RCHAT_ = 1'($urandom_range(0, 1));
      RCHBT_ = 1'($urandom_range(0, 1));
      #1;
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL chan_rand[%0d]: got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_high_read();
    RCHAT_ = 1'b1; RCHBT_ = 1'b0;
    load_count(32'h0006_0000);
    want = CH_EN ? 14'b00_0000_0000_0011 : 14'b0;
    checks++;
    if (chbt_o !== want || chat_o !== '0) begin
      errors++; $display("FAIL high_read: chbt %h chat %h want %h 0", chbt_o, chat_o, want);
    end
    for (int i = 0; i < 6; i++) begin
      RCHAT_ = 1'($urandom_range(0, 1));
      RCHBT_ = 1'($urandom_range(0, 1));
      load_count($urandom);
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rand_load[%0d]: got %h want %h", i, obs, exp_v); end
      drive_pulse($urandom_range(3, 5), $urandom_range(3, 5));
      exp_cnt = exp_cnt + 1;
      exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rand_inc[%0d]: got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_wrap_reset();
    RCHAT_ = 1'b0; RCHBT_ = 1'b0;
    load_count(32'hFFFF_FFFF);
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_full: got %h want %h", obs, exp_v); end
    drive_pulse(3, 3);
    exp_cnt = exp_cnt + 1;
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v || fs_o !== '0) begin errors++; $display("FAIL wrap_zero: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 3; i++) drive_pulse(3, 4);
    exp_cnt = exp_cnt + 3;
    #2;
    SIM_RST_ = 1'b0;
    #1;
    exp_cnt = '0;
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL async_reset: got %h want %h", obs, exp_v); end
    step(2);
    SIM_RST_ = 1'b1;
    step(2);
    drive_pulse(4, 3);
    exp_cnt = exp_cnt + 1;
    exp_v = model(exp_cnt, exp_f1, RCHAT_, RCHBT_);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL resume_count: got %h want %h", obs, exp_v); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_edge();
    test_count();
    test_channel_read();
    test_high_read();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
